// File: rtl/updown_modulo_counter.sv
// ---------------------------------------------------------------------------
// updown_modulo_counter
//   Up/down modulo counter with a step prescaler, synchronous clear/load,
//   wrap or saturate behaviour at the range ends, a registered terminal-count
//   pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH    : count / load_val width
//   MAX      : highest legal count (1 .. 2**WIDTH-1)
//   SATURATE : 0 = wrap at range ends, 1 = hold at range ends
//   PRESCALE : qualifying step requests per count change (>= 1)
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear of count and prescaler (highest priority)
//   load      in   synchronous load of min(load_val, MAX)
//   load_val  in   [WIDTH] load value
//   incr      in   step-up request
//   decr      in   step-down request (both high = no-op)
//   ovf_clr   in   clears the sticky overflow flag
//   count_reg out  [WIDTH] current count
//   tc        out  one-cycle pulse on a range-end step
//   ovf       out  sticky range-end flag
// ---------------------------------------------------------------------------
module updown_modulo_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX      = 2**WIDTH-1,
   parameter bit          SATURATE = 1'b0,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             incr,
   input  logic             decr,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count_reg,
   output logic             tc,
   output logic             ovf
);

   localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
   localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]    pre;
   logic [PW-1:0]    pre_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             req;
   logic             up;
   logic             step;
   logic             at_end;
   logic             evt;

   always_comb begin
      req     = incr ^ decr;
      up      = incr;
      step    = req && (pre == PRE_LAST);
      // Range end in the current direction; explicit compares keep the count
      // inside 0..MAX even when MAX is not a power-of-two boundary.
      at_end  = up ? (count_reg == MAX_V) : (count_reg == '0);
      pre_nxt = (pre == PRE_LAST) ? '0 : pre + PW'(1);

      count_nxt = count_reg;
      if (up)
         count_nxt = at_end ? (SATURATE ? MAX_V : '0) : count_reg + WIDTH'(1);
      else
         count_nxt = at_end ? (SATURATE ? '0 : MAX_V) : count_reg - WIDTH'(1);

      // clr/load discard any step in the same cycle, so no event either.
      evt = step && at_end && !clr && !load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
         pre       <= '0;
      end else if (clr) begin
         count_reg <= '0;
         pre       <= '0;
      end else if (load) begin
         count_reg <= (load_val > MAX_V) ? MAX_V : load_val;
         pre       <= '0;
      end else begin
         if (req)  pre       <= pre_nxt;
         if (step) count_reg <= count_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tc <= 1'b0;
      else        tc <= evt;
   end

   // A new event wins over ovf_clr in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ovf <= 1'b0;
      else if (evt)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

endmodule

// File: tb/tb_updown_modulo_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_modulo_counter
//   Directed bench. Five counter configurations share one set of stimulus
//   signals; each scenario task checks the instance it targets. Observed
//   values are packed as {count, tc, ovf}.
// ---------------------------------------------------------------------------
module tb_updown_modulo_counter;

   logic       clk = 1'b0;
   logic       rst_n, clr, load, incr, decr, ovf_clr;
   logic [7:0] load_val;

   logic [7:0] c_def, c_wrap, c_sat, c_pre, c_150;
   logic       tc_def, tc_wrap, tc_sat, tc_pre, tc_150;
   logic       ov_def, ov_wrap, ov_sat, ov_pre, ov_150;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   updown_modulo_counter u_def (.clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
      .load_val(load_val), .incr(incr), .decr(decr), .ovf_clr(ovf_clr),
      .count_reg(c_def), .tc(tc_def), .ovf(ov_def));

   updown_modulo_counter #(.MAX(9)) u_wrap (.clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
      .load_val(load_val), .incr(incr), .decr(decr), .ovf_clr(ovf_clr),
      .count_reg(c_wrap), .tc(tc_wrap), .ovf(ov_wrap));

   updown_modulo_counter #(.MAX(9), .SATURATE(1'b1)) u_sat (.clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
      .load_val(load_val), .incr(incr), .decr(decr), .ovf_clr(ovf_clr),
      .count_reg(c_sat), .tc(tc_sat), .ovf(ov_sat));

   updown_modulo_counter #(.PRESCALE(3)) u_pre (.clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
      .load_val(load_val), .incr(incr), .decr(decr), .ovf_clr(ovf_clr),
      .count_reg(c_pre), .tc(tc_pre), .ovf(ov_pre));

   updown_modulo_counter #(.MAX(150)) u_150 (.clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
      .load_val(load_val), .incr(incr), .decr(decr), .ovf_clr(ovf_clr),
      .count_reg(c_150), .tc(tc_150), .ovf(ov_150));

   // One rising edge, then settle 1 time unit: outputs are stable and inputs
   // may be changed for the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 0; load = 0; load_val = 0; incr = 0; decr = 0; ovf_clr = 0;
      #2;  // no clock edge has occurred yet
      if ({c_def,tc_def,ov_def} !== {8'd0,2'b00}) begin bad++; $display("FAIL rst_async got=%h want=%h", {c_def,tc_def,ov_def}, {8'd0,2'b00}); end total++;
      tick();
      rst_n = 1'b1;
      incr = 1'b1;
      tick();
      if ({c_def,tc_def,ov_def} !== {8'd1,2'b00}) begin bad++; $display("FAIL rst_up1 got=%h want=%h", {c_def,tc_def,ov_def}, {8'd1,2'b00}); end total++;
      tick();
      if ({c_def,tc_def,ov_def} !== {8'd2,2'b00}) begin bad++; $display("FAIL rst_up2 got=%h want=%h", {c_def,tc_def,ov_def}, {8'd2,2'b00}); end total++;
      tick();
      if ({c_def,tc_def,ov_def} !== {8'd3,2'b00}) begin bad++; $display("FAIL rst_up3 got=%h want=%h", {c_def,tc_def,ov_def}, {8'd3,2'b00}); end total++;
      tick();
      if ({c_def,tc_def,ov_def} !== {8'd4,2'b00}) begin bad++; $display("FAIL rst_up4 got=%h want=%h", {c_def,tc_def,ov_def}, {8'd4,2'b00}); end total++;
      incr = 1'b0;
      tick();
      if ({c_def,tc_def,ov_def} !== {8'd4,2'b00}) begin bad++; $display("FAIL rst_hold got=%h want=%h", {c_def,tc_def,ov_def}, {8'd4,2'b00}); end total++;
   endtask

   task automatic test_wrap();
      clr = 1; ovf_clr = 1; tick(); clr = 0; ovf_clr = 0;
      load = 1; load_val = 8'd9; tick(); load = 0;
      if ({c_wrap,tc_wrap,ov_wrap} !== {8'd9,2'b00}) begin bad++; $display("FAIL wrap_load got=%h want=%h", {c_wrap,tc_wrap,ov_wrap}, {8'd9,2'b00}); end total++;
      incr = 1; tick(); incr = 0;
      if ({c_wrap,tc_wrap,ov_wrap} !== {8'd0,2'b11}) begin bad++; $display("FAIL wrap_up got=%h want=%h", {c_wrap,tc_wrap,ov_wrap}, {8'd0,2'b11}); end total++;
      tick();
      if ({c_wrap,tc_wrap,ov_wrap} !== {8'd0,2'b01}) begin bad++; $display("FAIL wrap_tc_drop got=%h want=%h", {c_wrap,tc_wrap,ov_wrap}, {8'd0,2'b01}); end total++;
      decr = 1; tick(); decr = 0;
      if ({c_wrap,tc_wrap,ov_wrap} !== {8'd9,2'b11}) begin bad++; $display("FAIL wrap_down got=%h want=%h", {c_wrap,tc_wrap,ov_wrap}, {8'd9,2'b11}); end total++;
      ovf_clr = 1; tick(); ovf_clr = 0;
      if ({c_wrap,tc_wrap,ov_wrap} !== {8'd9,2'b00}) begin bad++; $display("FAIL wrap_ovf_clr got=%h want=%h", {c_wrap,tc_wrap,ov_wrap}, {8'd9,2'b00}); end total++;
   endtask

   task automatic test_saturate();
      clr = 1; ovf_clr = 1; tick(); clr = 0; ovf_clr = 0;
      load = 1; load_val = 8'd8; tick(); load = 0;
      incr = 1;
      tick();
      if ({c_sat,tc_sat,ov_sat} !== {8'd9,2'b00}) begin bad++; $display("FAIL sat_up1 got=%h want=%h", {c_sat,tc_sat,ov_sat}, {8'd9,2'b00}); end total++;
      tick();
      if ({c_sat,tc_sat,ov_sat} !== {8'd9,2'b11}) begin bad++; $display("FAIL sat_up2 got=%h want=%h", {c_sat,tc_sat,ov_sat}, {8'd9,2'b11}); end total++;
      tick();
      if ({c_sat,tc_sat,ov_sat} !== {8'd9,2'b11}) begin bad++; $display("FAIL sat_up3 got=%h want=%h", {c_sat,tc_sat,ov_sat}, {8'd9,2'b11}); end total++;
      incr = 0; ovf_clr = 1; tick(); ovf_clr = 0;
      clr = 1; tick(); clr = 0;
      if ({c_sat,tc_sat,ov_sat} !== {8'd0,2'b00}) begin bad++; $display("FAIL sat_clr got=%h want=%h", {c_sat,tc_sat,ov_sat}, {8'd0,2'b00}); end total++;
      decr = 1; tick(); decr = 0;
      if ({c_sat,tc_sat,ov_sat} !== {8'd0,2'b11}) begin bad++; $display("FAIL sat_down0 got=%h want=%h", {c_sat,tc_sat,ov_sat}, {8'd0,2'b11}); end total++;
      tick();
      if ({c_sat,tc_sat,ov_sat} !== {8'd0,2'b01}) begin bad++; $display("FAIL sat_tc_drop got=%h want=%h", {c_sat,tc_sat,ov_sat}, {8'd0,2'b01}); end total++;
   endtask

   task automatic test_prescale();
      logic [7:0] exp_cnt [6];
      exp_cnt = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
      clr = 1; ovf_clr = 1; tick(); clr = 0; ovf_clr = 0;
      incr = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (c_pre !== exp_cnt[i]) begin bad++; $display("FAIL pre_req%0d got=%0d want=%0d", i+1, c_pre, exp_cnt[i]); end total++;
      end
      // Both high: neither count nor prescaler move.
      decr = 1; tick(); tick();
      if (c_pre !== 8'd2) begin bad++; $display("FAIL pre_both got=%0d want=%0d", c_pre, 8'd2); end total++;
      decr = 0; tick();
      if (c_pre !== 8'd2) begin bad++; $display("FAIL pre_both_noadv got=%0d want=%0d", c_pre, 8'd2); end total++;
      tick(); tick();
      if (c_pre !== 8'd3) begin bad++; $display("FAIL pre_after_both got=%0d want=%0d", c_pre, 8'd3); end total++;
      // Direction change mid-prescale keeps the prescaler: 1 up + 2 down = one down step.
      tick(); incr = 0; decr = 1; tick(); tick(); decr = 0;
      if (c_pre !== 8'd2) begin bad++; $display("FAIL pre_dir_change got=%0d want=%0d", c_pre, 8'd2); end total++;
   endtask

   task automatic test_priority();
      clr = 1; load = 1; load_val = 8'd5; incr = 1; tick(); clr = 0; incr = 0;
      if ({c_def,tc_def} !== {8'd0,1'b0}) begin bad++; $display("FAIL pri_clr got=%h want=%h", {c_def,tc_def}, {8'd0,1'b0}); end total++;
      load_val = 8'd200; tick(); load = 0;
      if (c_150 !== 8'd150) begin bad++; $display("FAIL pri_load_clamp got=%0d want=%0d", c_150, 8'd150); end total++;
      if (c_def !== 8'd200) begin bad++; $display("FAIL pri_load_full got=%0d want=%0d", c_def, 8'd200); end total++;
      incr = 1; tick(); incr = 0;
      if ({c_150,tc_150,ov_150} !== {8'd0,2'b11}) begin bad++; $display("FAIL pri_max150_wrap got=%h want=%h", {c_150,tc_150,ov_150}, {8'd0,2'b11}); end total++;
      load = 1; load_val = 8'd5; incr = 1; tick(); load = 0; incr = 0;
      if (c_def !== 8'd5) begin bad++; $display("FAIL pri_load_over_step got=%0d want=%0d", c_def, 8'd5); end total++;
      load = 1; load_val = 8'd255; tick(); load = 0;
      incr = 1; ovf_clr = 1; tick(); incr = 0;
      if ({c_def,tc_def,ov_def} !== {8'd0,2'b11}) begin bad++; $display("FAIL pri_ovf_set_wins got=%h want=%h", {c_def,tc_def,ov_def}, {8'd0,2'b11}); end total++;
      tick(); ovf_clr = 0;
      if ({c_def,tc_def,ov_def} !== {8'd0,2'b00}) begin bad++; $display("FAIL pri_ovf_clr got=%h want=%h", {c_def,tc_def,ov_def}, {8'd0,2'b00}); end total++;
   endtask

   task automatic test_reset_mid();
      clr = 1; ovf_clr = 1; tick(); clr = 0; ovf_clr = 0;
      decr = 1; tick(); tick(); tick(); decr = 0;
      if ({c_pre,tc_pre,ov_pre} !== {8'd255,2'b11}) begin bad++; $display("FAIL mid_setup_wrap got=%h want=%h", {c_pre,tc_pre,ov_pre}, {8'd255,2'b11}); end total++;
      load = 1; load_val = 8'd7; tick(); load = 0;
      incr = 1; tick(); tick();
      if ({c_pre,ov_pre} !== {8'd7,1'b1}) begin bad++; $display("FAIL mid_pre2 got=%h want=%h", {c_pre,ov_pre}, {8'd7,1'b1}); end total++;
      rst_n = 1'b0;
      #1;
      if ({c_pre,tc_pre,ov_pre} !== {8'd0,2'b00}) begin bad++; $display("FAIL mid_async_rst got=%h want=%h", {c_pre,tc_pre,ov_pre}, {8'd0,2'b00}); end total++;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      if (c_pre !== 8'd0) begin bad++; $display("FAIL mid_after2 got=%0d want=%0d", c_pre, 8'd0); end total++;
      tick();
      if (c_pre !== 8'd1) begin bad++; $display("FAIL mid_after3 got=%0d want=%0d", c_pre, 8'd1); end total++;
      incr = 0;
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_saturate();
      test_prescale();
      test_priority();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
